// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_pkg                                                |
// | Description : Shared opcodes, ALU select codes, FSM state encodings  |
// |               and opcode classes for the accumulator CPU.            |
// | Revision    : 1.0 - initial multicycle release                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

    // 4-bit opcode encodings; wider opcode fields are zero-extended
    localparam logic [3:0] c_op_nop   = 4'b0000;
    localparam logic [3:0] c_op_load  = 4'b0001;
    localparam logic [3:0] c_op_store = 4'b0010;
    localparam logic [3:0] c_op_add   = 4'b0011;
    localparam logic [3:0] c_op_sub   = 4'b0100;
    localparam logic [3:0] c_op_and   = 4'b0101;
    localparam logic [3:0] c_op_or    = 4'b0110;
    localparam logic [3:0] c_op_not   = 4'b0111;
    localparam logic [3:0] c_op_loadb = 4'b1000;
    localparam logic [3:0] c_op_jmp   = 4'b1001;
    localparam logic [3:0] c_op_jz    = 4'b1010;
    localparam logic [3:0] c_op_halt  = 4'b1111;

    // ALU select codes, shared with the ALU
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_not = 3'b100;

    // Control FSM states; 6 and 7 are unreachable
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_MEM     = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/cu_opcode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cu_opcode_decoder                                      |
// | Description : Combinational opcode classifier for the control unit. |
// | Revision    : 1.0 - initial multicycle release                       |
// +----------------------------------------------------------------------+
module cu_opcode_decoder
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic [2:0]          alu_sel,
    output logic                is_store,
    output logic                is_loadb,
    output logic                is_jz
);

    // Classify the opcode; anything outside the table is illegal
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_sel  = c_alu_add;
        is_store = 1'b0;
        is_loadb = 1'b0;
        is_jz    = 1'b0;
        case (opcode)
            OPCODE_W'(c_op_nop):   op_class = CLS_NOP;
            OPCODE_W'(c_op_load):  op_class = CLS_MEM;
            OPCODE_W'(c_op_store): begin op_class = CLS_MEM; is_store = 1'b1; end
            OPCODE_W'(c_op_add):   begin op_class = CLS_ALU; alu_sel = c_alu_add; end
            OPCODE_W'(c_op_sub):   begin op_class = CLS_ALU; alu_sel = c_alu_sub; end
            OPCODE_W'(c_op_and):   begin op_class = CLS_ALU; alu_sel = c_alu_and; end
            OPCODE_W'(c_op_or):    begin op_class = CLS_ALU; alu_sel = c_alu_or;  end
            OPCODE_W'(c_op_not):   begin op_class = CLS_ALU; alu_sel = c_alu_not; end
            OPCODE_W'(c_op_loadb): begin op_class = CLS_MEM; is_loadb = 1'b1; end
            OPCODE_W'(c_op_jmp):   op_class = CLS_JUMP;
            OPCODE_W'(c_op_jz):    begin op_class = CLS_JUMP; is_jz = 1'b1; end
            OPCODE_W'(c_op_halt):  op_class = CLS_HALT;
            default:               op_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : multicycle_control_unit                                |
// | Description : Fetch/decode/execute/memory sequencer for the         |
// |               accumulator CPU with req/ready memory handshake.      |
// | Revision    : 1.0 - initial multicycle release                       |
// +----------------------------------------------------------------------+
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALU_SEL_W = 3,
    parameter int STATE_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero_flag,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 addr_sel,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 loadA,
    output logic                 loadB,
    output logic                 a_src,
    output logic [ALU_SEL_W-1:0] aluSel,
    output logic                 halted,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state_dbg
);

    state_t    r_state;
    state_t    w_next;
    logic      r_illegal;
    logic      w_set_illegal;
    op_class_t w_class;
    logic [2:0] w_alu_sel;
    logic      w_is_store;
    logic      w_is_loadb;
    logic      w_is_jz;

    cu_opcode_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .opcode   (opcode),
        .op_class (w_class),
        .alu_sel  (w_alu_sel),
        .is_store (w_is_store),
        .is_loadb (w_is_loadb),
        .is_jz    (w_is_jz)
    );

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; strobes are held low while reset is asserted
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        addr_sel      = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        loadA         = 1'b0;
        loadB         = 1'b0;
        a_src         = 1'b0;
        aluSel        = '0;
        halted        = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_FETCH;
                end
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        w_next  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_class)
                        CLS_MEM:     w_next = S_MEM;
                        CLS_HALT:    w_next = S_HALT;
                        CLS_ILLEGAL: begin w_next = S_EXEC; w_set_illegal = 1'b1; end
                        default:     w_next = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    w_next = S_FETCH;
                    if (w_class == CLS_ALU) begin
                        loadA  = 1'b1;
                        aluSel = ALU_SEL_W'(w_alu_sel);
                    end else if (w_class == CLS_JUMP) begin
                        pc_load = w_is_jz ? zero_flag : 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    addr_sel  = 1'b1;
                    mem_write = w_is_store;
                    if (mem_ready) begin
                        w_next = S_FETCH;
                        if (w_is_loadb) begin
                            loadB = 1'b1;
                        end else if (!w_is_store) begin
                            loadA = 1'b1;
                            a_src = 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (start) w_next = S_FETCH;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign illegal   = r_illegal;
    assign state_dbg = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_multicycle_control_unit                             |
// | Description : Directed self-checking bench for the control unit.    |
// | Revision    : 1.0 - initial multicycle release                       |
// +----------------------------------------------------------------------+
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ready;
    logic       mem_req, mem_write, addr_sel, ir_load, pc_inc, pc_load;
    logic       loadA, loadB, a_src, halted, illegal;
    logic [2:0] aluSel;
    logic [2:0] state_dbg;
    logic [12:0] obs;

    int checks = 0;
    int errors = 0;

    // Strobe vector: {req,wr,asel,irl,pinc,pld,lA,lB,asrc,hlt,aluSel}
    localparam logic [12:0] NONE = 13'b0000000000_000;
    localparam logic [12:0] FET  = 13'b1001100000_000;
    localparam logic [12:0] MEMW = 13'b1010000000_000;
    localparam logic [12:0] LDA  = 13'b1010001010_000;
    localparam logic [12:0] LDB  = 13'b1010000100_000;
    localparam logic [12:0] STO  = 13'b1110000000_000;
    localparam logic [12:0] ALU  = 13'b0000001000_000;
    localparam logic [12:0] PLD  = 13'b0000010000_000;
    localparam logic [12:0] HLT  = 13'b0000000001_000;

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_write, addr_sel, ir_load, pc_inc, pc_load,
                  loadA, loadB, a_src, halted, aluSel};

    multicycle_control_unit #(
        .OPCODE_W  (4),
        .ALU_SEL_W (3),
        .STATE_W   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .loadA     (loadA),
        .loadB     (loadB),
        .a_src     (a_src),
        .aluSel    (aluSel),
        .halted    (halted),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    // Strobe exclusivity and write-implies-request, every cycle
    always @(negedge clk) begin
        checks++;
        if ((pc_inc && pc_load) || (loadA && loadB) || (ir_load && mem_write) ||
            (mem_write && !mem_req)) begin
            errors++;
            $display("FAIL exclusivity t=%0t strobes=%b", $time, obs);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; opcode = 4'b0011; zero_flag = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== NONE || state_dbg !== 3'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset strobes=%b st=%0d ill=%b, expected %b st=0 ill=0",
                     obs, state_dbg, illegal, NONE);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
    endtask

    task automatic test_add();
        logic [12:0] exp [3];
        logic [2:0]  st  [3];
        exp = '{FET, NONE, ALU};
        st  = '{3'd1, 3'd2, 3'd3};
        start = 1'b1; opcode = 4'b0011; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== NONE || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL add_idle strobes=%b st=%0d, expected %b st=0", obs, state_dbg, NONE);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i] || state_dbg !== st[i]) begin
                errors++;
                $display("FAIL add cyc%0d strobes=%b st=%0d, expected %b st=%0d",
                         i, obs, state_dbg, exp[i], st[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [12:0] exp [5];
        logic [2:0]  st  [5];
        logic        rdy [5];
        exp = '{FET, NONE, MEMW, MEMW, LDA};
        st  = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd4};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        opcode = 4'b0001; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i] || state_dbg !== st[i]) begin
                errors++;
                $display("FAIL load_wait cyc%0d strobes=%b st=%0d, expected %b st=%0d",
                         i, obs, state_dbg, exp[i], st[i]);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_store_jz();
        logic [12:0] exp [9];
        logic [2:0]  st  [9];
        logic [3:0]  op  [9];
        logic        zf  [9];
        exp = '{FET, NONE, STO, FET, NONE, NONE, FET, NONE, PLD};
        st  = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        op  = '{4'd2, 4'd2, 4'd2, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10};
        zf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            opcode = op[i]; zero_flag = zf[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i] || state_dbg !== st[i]) begin
                errors++;
                $display("FAIL store_jz cyc%0d strobes=%b st=%0d, expected %b st=%0d",
                         i, obs, state_dbg, exp[i], st[i]);
            end
            @(posedge clk); #1;
        end
        zero_flag = 1'b0;
    endtask

    task automatic test_illegal();
        logic [12:0] exp [6];
        logic [2:0]  st  [6];
        logic [3:0]  op  [6];
        logic        ill [6];
        exp = '{FET, NONE, NONE, FET, NONE, NONE};
        st  = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        op  = '{4'd11, 4'd11, 4'd11, 4'd0, 4'd0, 4'd0};
        ill = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = op[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i] || state_dbg !== st[i] || illegal !== ill[i]) begin
                errors++;
                $display("FAIL illegal cyc%0d strobes=%b st=%0d ill=%b, expected %b st=%0d ill=%b",
                         i, obs, state_dbg, illegal, exp[i], st[i], ill[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        logic [12:0] exp [5];
        logic [2:0]  st  [5];
        logic        go  [5];
        exp = '{FET, NONE, HLT, HLT, HLT};
        st  = '{3'd1, 3'd2, 3'd5, 3'd5, 3'd5};
        go  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 4'b1111; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = go[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i] || state_dbg !== st[i] || illegal !== 1'b1) begin
                errors++;
                $display("FAIL halt cyc%0d strobes=%b st=%0d ill=%b, expected %b st=%0d ill=1",
                         i, obs, state_dbg, illegal, exp[i], st[i]);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp [5];
        logic [2:0]  st  [5];
        logic        rdy [5];
        logic        rn  [5];
        logic        ill [5];
        exp = '{FET, NONE, MEMW, NONE, NONE};
        st  = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd0};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rn  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ill = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i]; rst_n = rn[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i] || state_dbg !== st[i] || illegal !== ill[i]) begin
                errors++;
                $display("FAIL reset_mid cyc%0d strobes=%b st=%0d ill=%b, expected %b st=%0d ill=%b",
                         i, obs, state_dbg, illegal, exp[i], st[i], ill[i]);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1; mem_ready = 1'b1;
    endtask

    task automatic test_sweep();
        logic [12:0] want;
        logic [2:0]  wst;
        start = 1'b1; mem_ready = 1'b1; zero_flag = 1'b0; opcode = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int op = 0; op < 16; op++) begin
            opcode = 4'(op);
            case (op)
                0:       begin want = NONE;          wst = 3'd3; end
                1:       begin want = LDA;           wst = 3'd4; end
                2:       begin want = STO;           wst = 3'd4; end
                3:       begin want = ALU;           wst = 3'd3; end
                4:       begin want = ALU | 13'd1;   wst = 3'd3; end
                5:       begin want = ALU | 13'd2;   wst = 3'd3; end
                6:       begin want = ALU | 13'd3;   wst = 3'd3; end
                7:       begin want = ALU | 13'd4;   wst = 3'd3; end
                8:       begin want = LDB;           wst = 3'd4; end
                9:       begin want = PLD;           wst = 3'd3; end
                15:      begin want = HLT;           wst = 3'd5; end
                default: begin want = NONE;          wst = 3'd3; end
            endcase
            @(negedge clk);
            checks++;
            if (obs !== FET || state_dbg !== 3'd1) begin
                errors++;
                $display("FAIL sweep_fetch op=%0d strobes=%b st=%0d, expected %b st=1",
                         op, obs, state_dbg, FET);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (obs !== NONE || state_dbg !== 3'd2) begin
                errors++;
                $display("FAIL sweep_decode op=%0d strobes=%b st=%0d, expected %b st=2",
                         op, obs, state_dbg, NONE);
            end
            @(posedge clk); #1;
            if (op == 15) start = 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== want || state_dbg !== wst) begin
                errors++;
                $display("FAIL sweep_exec op=%0d strobes=%b st=%0d, expected %b st=%0d",
                         op, obs, state_dbg, want, wst);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd1 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL sweep_end st=%0d ill=%b, expected st=1 ill=1", state_dbg, illegal);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store_jz();
        test_illegal();
        test_halt();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle opcode decoder of the accumulator CPU.
- Sequences each instruction through fetch, decode, execute and memory states.
- Handshakes with instruction/data memory through a req/ready pair, so wait states are allowed.
- Adds LOADB, NOP, jumps, HALT and illegal-opcode detection. Drives the PC, IR, accumulator (A), B register and ALU select.

Parameters:
- OPCODE_W, 4, opcode field width; opcodes are zero-extended from the 4-bit encodings listed below.
- ALU_SEL_W, 3, ALU select width.
- STATE_W, 3, state register width, exported on the debug port.

Ports:
- clk  in  1  system clock; everything is updated on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  leaves IDLE or HALT and begins fetching; sampled only in those two states.
- opcode  in  OPCODE_W  opcode field of the instruction register; valid from DECODE onward.
- zero_flag  in  1  accumulator==0 status from the datapath.
- mem_ready  in  1  memory completes the current access this cycle; ignored while mem_req=0.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a write; only asserted together with mem_req.
- addr_sel  out  1  address source: 0 = PC (fetch), 1 = IR address field (data access or jump target).
- ir_load  out  1  capture memory read data into IR.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= IR address field.
- loadA  out  1  write accumulator.
- loadB  out  1  write B register.
- a_src  out  1  accumulator source: 0 = ALU result, 1 = memory data.
- aluSel  out  ALU_SEL_W  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT.
- halted  out  1  high while in HALT.
- illegal  out  1  sticky; set when an undefined opcode is decoded.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Opcodes:
  - 0000 NOP
  - 0001 LOAD (A <= mem)
  - 0010 STORE (mem <= A)
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 NOT
  - 1000 LOADB (B <= mem)
  - 1001 JMP
  - 1010 JZ
  - 1111 HALT
  - all others are illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5. Encodings 6 and 7 are unreachable and recover to IDLE.
- Outputs are combinational from state, opcode and mem_ready. Every strobe is 0 unless listed for the state. aluSel defaults to 000 and a_src to 0.
- Reset (rst_n=0 at a clock edge, including mid-instruction):
  - state <= IDLE and illegal <= 0.
  - All strobes are 0 during the reset cycle.
  - An outstanding memory request is abandoned; memory must tolerate mem_req dropping.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: mem_req=1, addr_sel=0. On mem_ready=1: ir_load=1, pc_inc=1, -> DECODE. Otherwise stay, holding the request.
- DECODE: no strobes.
  - LOAD, STORE, LOADB -> MEM.
  - HALT -> HALT.
  - Everything else -> EXEC.
  - Illegal opcode: illegal <= 1, then -> EXEC, where it executes as a NOP.
- EXEC, then -> FETCH:
  - ALU ops: loadA=1 with aluSel per table.
  - JMP: pc_load=1.
  - JZ: pc_load = zero_flag.
  - NOP and illegal opcodes: no strobes.
- MEM: mem_req=1, addr_sel=1, mem_write = (opcode==STORE). On mem_ready=1:
  - LOAD: loadA=1, a_src=1.
  - LOADB: loadB=1.
  - then -> FETCH.
  - Otherwise stay, holding the request.
- HALT: halted=1; start=1 -> FETCH, with PC continuing from the instruction after HALT.
- Latency with zero-wait memory (mem_ready tied high): 3 cycles for every instruction. Each memory wait cycle adds 1.
- Strobe exclusivity: pc_inc and pc_load are never high together, nor loadA and loadB, nor ir_load and mem_write.
- start is ignored outside IDLE and HALT.
- illegal clears only on reset.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams;
  - ALU select codes (shared with the ALU);
  - state encodings.
- One combinational sub-module, cu_opcode_decoder, maps an opcode to:
  - its class (alu, mem, jump, halt, nop, illegal);
  - aluSel, is_store, is_loadb.
- The FSM lives in multicycle_control_unit.

Test Plan:
- Reset, then start=1, mem_ready=1, opcode=0011 -> cycle 1: mem_req=1, ir_load=1, pc_inc=1; cycle 2: no strobes; cycle 3: loadA=1, aluSel=000; cycle 4: back in FETCH.
- LOAD with mem_ready low for 2 MEM cycles -> mem_req=1 and addr_sel=1 held for 3 cycles; loadA=1 and a_src=1 only in the cycle mem_ready=1.
- STORE -> in MEM, mem_req=1, mem_write=1, no loadA. JZ with zero_flag=0 -> pc_load=0; with zero_flag=1 -> pc_load=1 in EXEC.
- Opcode 1011 -> illegal rises after DECODE and stays 1 through later instructions; EXEC asserts no strobes.
- HALT -> halted=1 and stays until start=1, then FETCH. rst_n=0 during a stalled MEM cycle -> next cycle IDLE, all strobes 0, illegal=0.
- Sweep all 16 opcodes -> aluSel, loadA, loadB and mem_write match the table. Check strobe exclusivity every cycle.
